// File: rtl/demultiplexer4_tdm.sv
// Receiving end of a 4-slot TDM link: aligns to a frame-start marker, collects
// one serial bit per slot and presents the rebuilt 4-bit word with a strobe.
module demultiplexer4_tdm #(
  parameter bit SYNC_EVERY_FRAME = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Y,
  input  logic       Valid,
  input  logic       Sync,
  output logic [3:0] X,
  output logic [1:0] Address,
  output logic       Ready,
  output logic       Locked,
  output logic       SyncErr
);

  typedef enum logic {HUNT, RECEIVE} state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [2:0] s_q, s_d;
  logic [3:0] x_q, x_d;
  logic       ready_q, ready_d;
  logic       locked_q, locked_d;
  logic       syncerr_q, syncerr_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    s_d       = s_q;
    x_d       = x_q;
    ready_d   = 1'b0;
    syncerr_d = 1'b0;
    if (Valid) begin
      case (state_q)
        HUNT: begin
          if (Sync) begin
            s_d     = {2'b00, Y};
            addr_d  = 2'd1;
            state_d = RECEIVE;
          end
        end
        RECEIVE: begin
          if (Sync && (addr_q != 2'd0)) begin
            // Mid-frame marker: drop the partial frame and restart at slot 0.
            syncerr_d = 1'b1;
            s_d       = {2'b00, Y};
            addr_d    = 2'd1;
          end else begin
            case (addr_q)
              2'd0: begin s_d[0] = Y; addr_d = 2'd1; end
              2'd1: begin s_d[1] = Y; addr_d = 2'd2; end
              2'd2: begin s_d[2] = Y; addr_d = 2'd3; end
              default: begin
                x_d     = {Y, s_q};
                ready_d = 1'b1;
                addr_d  = 2'd0;
                state_d = SYNC_EVERY_FRAME ? HUNT : RECEIVE;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == RECEIVE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= HUNT;
      addr_q    <= 2'd0;
      s_q       <= 3'd0;
      x_q       <= 4'd0;
      ready_q   <= 1'b0;
      locked_q  <= 1'b0;
      syncerr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      s_q       <= s_d;
      x_q       <= x_d;
      ready_q   <= ready_d;
      locked_q  <= locked_d;
      syncerr_q <= syncerr_d;
    end
  end

  assign X       = x_q;
  assign Address = addr_q;
  assign Ready   = ready_q;
  assign Locked  = locked_q;
  assign SyncErr = syncerr_q;

endmodule
